// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter
//   Single owner of the shared pipelined main memory. Arbitrates an I-cache line
//   fill, a D-cache line fill and a single-word D-side write-through. A fill is
//   issued as a burst of LINE_WORDS back-to-back reads; returned words are
//   streamed to the owning cache together with their index in the line.
//
// Ports
//   clk, rst_n                     clock (rising edge), synchronous active-low reset
//   i_req/i_addr, i_ack            I fill request (level), any address in the line, ack pulse
//   d_req/d_addr, d_ack            D fill request (level), any address in the line, ack pulse
//   wr_req/wr_addr/wr_data, wr_ack write-through request, byte address, data, ack pulse
//   mem_en/mem_wr/mem_addr/mem_wdata  memory request side
//   mem_rdata/mem_rvalid           memory return side, one pulse per read, in order
//   fill_valid/fill_sel/fill_idx/fill_data  fill word stream (sel: 0 = I, 1 = D)
//
// ARB_MODE 0: write > D fill > I fill. ARB_MODE 1: write first, then the fill not
// served last wins when both fills are pending.
module line_fill_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          d_req,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          i_ack,
    output logic                          d_ack,
    output logic                          wr_ack,
    output logic                          mem_en,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_rvalid,
    output logic                          fill_valid,
    output logic                          fill_sel,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Byte offset bits inside one line (words are 2 bytes).
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((2 * LINE_WORDS) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]  ISSUE_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0]  RET_LAST  = IDX_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  RET_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StFillI, StFillD} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                rr_last_q, rr_last_d;  // 0 = I served last, 1 = D served last

    logic                pick_d;
    logic                owner;
    logic [ADDR_W-1:0]   req_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
            rr_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
            rr_last_q   <= rr_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_d      = base_q;
        rr_last_d   = rr_last_q;
        pick_d      = 1'b0;
        owner       = 1'b0;
        req_addr    = '0;

        i_ack      = 1'b0;
        d_ack      = 1'b0;
        wr_ack     = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_sel   = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;

        unique case (state_q)
            StIdle: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (wr_req) begin
                    state_d = StWrite;
                end else if (d_req || i_req) begin
                    if (d_req && i_req) begin
                        pick_d = (ARB_MODE == 0) ? 1'b1 : !rr_last_q;
                    end else begin
                        pick_d = d_req;
                    end
                    req_addr  = pick_d ? d_addr : i_addr;
                    state_d   = pick_d ? StFillD : StFillI;
                    rr_last_d = pick_d;
                    base_d    = req_addr & ~OFF_MASK;
                end
            end

            StWrite: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr & ~WORD_MASK;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
                state_d   = StIdle;
            end

            StFillI, StFillD: begin
                owner = (state_q == StFillD);
                if (issue_cnt_q != ISSUE_END) begin
                    mem_en      = 1'b1;
                    // base has the offset bits cleared, so OR never carries out of the line
                    mem_addr    = base_q | ADDR_W'({issue_cnt_q[IDX_W-1:0], 1'b0});
                    issue_cnt_d = issue_cnt_q + ISSUE_ONE;
                end
                if (mem_rvalid) begin
                    fill_valid = 1'b1;
                    fill_sel   = owner;
                    fill_idx   = ret_cnt_q;
                    fill_data  = mem_rdata;
                    ret_cnt_d  = ret_cnt_q + RET_ONE;
                    if (ret_cnt_q == RET_LAST) begin
                        i_ack   = !owner;
                        d_ack   = owner;
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter. Two instances share all inputs: u_fix
// (ARB_MODE 0) and u_rr (ARB_MODE 1). The memory model answers reads issued by
// u_fix four cycles later; both instances have identical timing, so both see
// the same return stream.
module tb_line_fill_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic i_req, d_req, wr_req;
    logic [AW-1:0] i_addr, d_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] mem_rdata;
    logic mem_rvalid;
    logic stray;

    logic i_ack0, d_ack0, wr_ack0, mem_en0, mem_wr0, fill_valid0, fill_sel0;
    logic [AW-1:0] mem_addr0;
    logic [DW-1:0] mem_wdata0, fill_data0;
    logic [2:0] fill_idx0;

    logic i_ack1, d_ack1, wr_ack1, mem_en1, mem_wr1, fill_valid1, fill_sel1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wdata1, fill_data1;
    logic [2:0] fill_idx1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .ARB_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .i_ack(i_ack0), .d_ack(d_ack0), .wr_ack(wr_ack0),
        .mem_en(mem_en0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_valid(fill_valid0), .fill_sel(fill_sel0), .fill_idx(fill_idx0),
        .fill_data(fill_data0)
    );

    line_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .i_ack(i_ack1), .d_ack(d_ack1), .wr_ack(wr_ack1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_valid(fill_valid1), .fill_sel(fill_sel1), .fill_idx(fill_idx1),
        .fill_data(fill_data1)
    );

    // Memory model: read captured at the edge ending its issue cycle, data returns
    // three register stages later (issue cycle c -> return cycle c+4).
    logic [3:0]    pv = '0;
    logic [AW-1:0] pa0 = '0, pa1 = '0, pa2 = '0, pa3 = '0;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always_ff @(posedge clk) begin
        pv  <= {pv[2:0], mem_en0 & ~mem_wr0};
        pa0 <= mem_addr0;
        pa1 <= pa0;
        pa2 <= pa1;
        pa3 <= pa2;
    end

    assign mem_rvalid = pv[3] | stray;
    assign mem_rdata  = pv[3] ? mdata(pa3) : 16'h7777;

    // Monitor: logs every issued request and every fill word, sampled at negedge.
    typedef struct {
        int            cyc;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        int            cyc;
        logic          sel;
        logic [2:0]    idx;
        logic [DW-1:0] data;
        logic          iack;
        logic          dack;
    } ret_t;

    iss_t iss0[$];
    ret_t ret0[$];
    ret_t ret1[$];
    int cyc = 0;
    int n_iack0 = 0, n_dack0 = 0, n_iack1 = 0, n_dack1 = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_en0) iss0.push_back('{cyc, mem_wr0, mem_addr0, mem_wdata0});
        if (fill_valid0) ret0.push_back('{cyc, fill_sel0, fill_idx0, fill_data0, i_ack0, d_ack0});
        if (fill_valid1) ret1.push_back('{cyc, fill_sel1, fill_idx1, fill_data1, i_ack1, d_ack1});
        n_iack0 = n_iack0 + int'(i_ack0);
        n_dack0 = n_dack0 + int'(d_ack0);
        n_iack1 = n_iack1 + int'(i_ack1);
        n_dack1 = n_dack1 + int'(d_ack1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next falling edge (monitor has logged that cycle).
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // which: 0 = d_ack0, 1 = i_ack0, 2 = any ack of u_rr, 3 = fill_valid0
    task automatic wait_sig(input int which, input string tag);
        bit hit = 1'b0;
        int n = 0;
        while (!hit && n < 60) begin
            tick();
            n++;
            case (which)
                0:       hit = d_ack0;
                1:       hit = i_ack0;
                2:       hit = i_ack1 | d_ack1;
                default: hit = fill_valid0;
            endcase
        end
        if (!hit) chk({tag, "_timeout"}, 64'(hit), 64'd1);
    endtask

    initial begin
        int t0;
        int mi, m0, m1;
        int own_n0, own_n1;
        int di0, ii0, di1, ii1;
        logic [3:0] own0, own1;

        rst_n   = 1'b0;
        stray   = 1'b0;
        wr_req  = 1'b1;
        d_req   = 1'b1;
        i_req   = 1'b1;
        wr_addr = 16'h4567;
        wr_data = 16'hBEEF;
        d_addr  = 16'h1236;
        i_addr  = 16'hFFFE;

        // Reset held two edges with every request high.
        tick();
        tick();
        chk("rst_mem_en", 64'({mem_en0, mem_en1}), 64'd0);
        chk("rst_mem_wr", 64'({mem_wr0, mem_wr1}), 64'd0);
        chk("rst_mem_addr", 64'({mem_addr0, mem_addr1}), 64'd0);
        chk("rst_mem_wdata", 64'({mem_wdata0, mem_wdata1}), 64'd0);
        chk("rst_acks", 64'({i_ack0, d_ack0, wr_ack0, i_ack1, d_ack1, wr_ack1}), 64'd0);
        chk("rst_fill", 64'({fill_valid0, fill_sel0, fill_idx0, fill_data0,
                             fill_valid1, fill_sel1, fill_idx1, fill_data1}), 64'd0);
        rst_n = 1'b1;

        // First operation after release: the write, with ack, on both instances.
        tick();
        chk("wr_en_wr", 64'({mem_en0, mem_wr0, mem_en1, mem_wr1}), 64'hF);
        chk("wr_addr", 64'(mem_addr0), 64'h4566);
        chk("wr_data", 64'(mem_wdata0), 64'hBEEF);
        chk("wr_ack", 64'({wr_ack0, wr_ack1}), 64'h3);
        wr_req = 1'b0;

        wait_sig(0, "d_fill");
        d_req = 1'b0;
        wait_sig(1, "i_fill");
        i_req = 1'b0;
        tick();

        // Write, then D fill 0x1230.., then I fill of the top line 0xFFF0..
        chk("p1_issue_count", 64'(iss0.size()), 64'd17);
        chk("p1_first_is_wr", 64'(iss0[0].wr), 64'd1);
        t0 = iss0[1].cyc;
        chk("d_grant_gap", 64'(t0 - iss0[0].cyc), 64'd2);
        for (int k = 0; k < LW; k++) begin
            chk($sformatf("d_rd_%0d", k),
                64'({iss0[1+k].wr, iss0[1+k].addr, 32'(iss0[1+k].cyc - t0)}),
                64'({1'b0, 16'h1230 + 16'(2*k), 32'(k)}));
            chk($sformatf("i_rd_%0d", k),
                64'({iss0[9+k].wr, iss0[9+k].addr, 32'(iss0[9+k].cyc - t0)}),
                64'({1'b0, 16'hFFF0 + 16'(2*k), 32'(13 + k)}));
        end
        chk("p1_ret_count", 64'({16'(ret0.size()), 16'(ret1.size())}), 64'h0010_0010);
        for (int k = 0; k < LW; k++) begin
            chk($sformatf("d_ret_%0d", k),
                64'({ret0[k].sel, ret0[k].idx, ret0[k].dack, ret0[k].iack, ret0[k].data,
                     16'(ret0[k].cyc - t0)}),
                64'({1'b1, 3'(k), k == LW-1, 1'b0, mdata(16'h1230 + 16'(2*k)), 16'(4 + k)}));
            chk($sformatf("i_ret_%0d", k),
                64'({ret0[8+k].sel, ret0[8+k].idx, ret0[8+k].dack, ret0[8+k].iack,
                     ret0[8+k].data, 16'(ret0[8+k].cyc - t0)}),
                64'({1'b0, 3'(k), 1'b0, k == LW-1, mdata(16'hFFF0 + 16'(2*k)), 16'(17 + k)}));
            chk($sformatf("rr_p1_%0d", k),
                64'({ret1[k].sel, ret1[k].idx, ret1[8+k].sel, ret1[8+k].idx}),
                64'({1'b1, 3'(k), 1'b0, 3'(k)}));
        end
        chk("p1_acks", 64'({8'(n_dack0), 8'(n_iack0), 8'(n_dack1), 8'(n_iack1)}),
            64'h0101_0101);

        // Stray return while idle.
        stray = 1'b1;
        tick();
        chk("stray_idle", 64'({fill_valid0, fill_valid1, mem_en0}), 64'd0);
        stray = 1'b0;

        // Both fills held for four u_rr grants.
        m0 = ret0.size();
        m1 = ret1.size();
        di0 = n_dack0; ii0 = n_iack0; di1 = n_dack1; ii1 = n_iack1;
        d_addr = 16'h0A10;
        i_addr = 16'h2002;
        d_req  = 1'b1;
        i_req  = 1'b1;
        for (int g = 0; g < 4; g++) wait_sig(2, $sformatf("rr_grant_%0d", g));
        d_req = 1'b0;
        i_req = 1'b0;
        tick();
        own0 = '0; own1 = '0; own_n0 = 0; own_n1 = 0;
        for (int k = m0; k < ret0.size(); k++) begin
            if (ret0[k].idx == 3'd0 && own_n0 < 4) begin
                own0[3-own_n0] = ret0[k].sel;
                own_n0++;
            end
        end
        for (int k = m1; k < ret1.size(); k++) begin
            if (ret1[k].idx == 3'd0 && own_n1 < 4) begin
                own1[3-own_n1] = ret1[k].sel;
                own_n1++;
            end
        end
        chk("rr_owners", 64'({own_n1, own1}), 64'({32'd4, 4'b1010}));
        chk("fix_owners", 64'({own_n0, own0}), 64'({32'd4, 4'b1111}));
        chk("rr_acks", 64'({8'(n_dack1 - di1), 8'(n_iack1 - ii1)}), 64'h0202);
        chk("fix_acks", 64'({8'(n_dack0 - di0), 8'(n_iack0 - ii0)}), 64'h0400);

        // Abort an I fill after three returned words.
        m0 = ret0.size();
        ii0 = n_iack0; ii1 = n_iack1;
        i_addr = 16'h0346;
        i_req  = 1'b1;
        for (int w = 0; w < 3; w++) wait_sig(3, $sformatf("abort_word_%0d", w));
        chk("abort_words", 64'(ret0.size() - m0), 64'd3);
        rst_n = 1'b0;
        i_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 1) rst_n = 1'b1;
            chk($sformatf("abort_quiet_%0d", k),
                64'({fill_valid0, fill_valid1, i_ack0, i_ack1, mem_en0, mem_en1}), 64'd0);
        end
        chk("abort_no_ack", 64'({8'(n_iack0 - ii0), 8'(n_iack1 - ii1)}), 64'd0);

        // Next grant starts from clean counters and a reset round-robin pointer.
        mi = iss0.size();
        m0 = ret0.size();
        m1 = ret1.size();
        d_addr = 16'h0B0E;
        i_addr = 16'h0C00;
        d_req  = 1'b1;
        i_req  = 1'b1;
        wait_sig(0, "post_abort");
        chk("post_abort_rr_dack", 64'(d_ack1), 64'd1);
        d_req = 1'b0;
        i_req = 1'b0;
        tick();
        chk("post_abort_first_rd", 64'({iss0[mi].wr, iss0[mi].addr}), 64'({1'b0, 16'h0B00}));
        chk("post_abort_issues", 64'(iss0.size() - mi), 64'd8);
        for (int k = 0; k < LW; k++) begin
            chk($sformatf("post_abort_ret_%0d", k),
                64'({ret0[m0+k].sel, ret0[m0+k].idx, ret0[m0+k].data,
                     ret1[m1+k].sel, ret1[m1+k].idx}),
                64'({1'b1, 3'(k), mdata(16'h0B00 + 16'(2*k)), 1'b1, 3'(k)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
